mux16_rr_arbiter: RTL and testbench



---
 rtl/mux16_rr_arbiter_pkg.sv | 13 +
 rtl/mux16_rr_arbiter_rr_pick4.sv | 33 +++
 rtl/mux16_rr_arbiter.sv | 77 +++++++
 tb/tb_mux16_rr_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants and state type for the four-way round-robin output arbiter.
package mux16_rr_arbiter_pkg;

    localparam int          ARB_NREQ     = 4;
    localparam int          ARB_W        = 16;
    localparam logic [1:0]  ARB_LAST_RST = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux16_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first request after `last`, wrapping back to `last`.
module rr_pick4
    import mux16_rr_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    input  logic       en,
    output logic [3:0] gnt,
    output logic [1:0] w
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt   = 4'b0000;
        w     = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        // k = 4 wraps to `last` itself, which is searched last
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        if (found && en) begin
            gnt[w] = 1'b1;
        end
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output word from four requesters.
// Optional burst priority hold is enabled with the ARB_LOCK_EN macro (adds the `lock` port).
module mux16_rr_arbiter
    import mux16_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = ARB_W,
    parameter int NREQ  = ARB_NREQ
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]  lock,
`endif
    input  logic             ready,
    output logic [NREQ-1:0]  gnt,
    output logic             valid,
    output logic [WIDTH-1:0] out
);

    arb_state_e       state_q;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       last_q;
    logic [1:0]       last_d;
    logic [1:0]       w;
    logic             accept;
    logic             any_gnt;
    logic [WIDTH-1:0] mux_d;

    assign accept = (state_q == EMPTY) | ready;

    // Grants are suppressed during reset so nothing looks captured while the registers are cleared
    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .en   (accept & ~reset),
        .gnt  (gnt),
        .w    (w)
    );

    assign any_gnt = |gnt;

    // Four-way AND-OR steering selected by the encoded winner
    assign mux_d = ({WIDTH{w == 2'd0}} & d0)
                 | ({WIDTH{w == 2'd1}} & d1)
                 | ({WIDTH{w == 2'd2}} & d2)
                 | ({WIDTH{w == 2'd3}} & d3);

`ifdef ARB_LOCK_EN
    // Storing w-1 makes w the first candidate again on the next beat
    assign last_d = lock[w] ? (w - 2'd1) : w;
`else
    assign last_d = w;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            out_q   <= '0;
            last_q  <= ARB_LAST_RST;
        end else if (any_gnt) begin
            state_q <= FULL;
            out_q   <= mux_d;
            last_q  <= last_d;
        end else if (ready && state_q == FULL) begin
            state_q <= EMPTY;
        end
    end

    assign valid = (state_q == FULL);
    assign out   = out_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed self-checking bench for mux16_rr_arbiter; the lock scenario runs only when ARB_LOCK_EN is defined.
module tb_mux16_rr_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] d0, d1, d2, d3;
    logic [3:0]  lock;
    logic        ready;
    logic [3:0]  gnt;
    logic        valid;
    logic [15:0] out_w;

    int n_cmp;
    int n_bad;

    mux16_rr_arbiter dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .ready (ready),
        .gnt   (gnt),
        .valid (valid),
        .out   (out_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0]  exp_g [5];
        logic [15:0] exp_o [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_o = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
        reset = 1'b1;
        req   = 4'b1111;
        ready = 1'b1;
        lock  = 4'b0000;
        d0 = 16'h1111; d1 = 16'h2222; d2 = 16'h3333; d3 = 16'h4444;
        tick();
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++;
        if (out_w !== 16'h0000) begin n_bad++; $display("FAIL reset_out got %h want 0000", out_w); end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (gnt !== exp_g[i]) begin n_bad++; $display("FAIL rr4_gnt[%0d] got %b want %b", i, gnt, exp_g[i]); end
            tick();
            n_cmp++;
            if (valid !== 1'b1 || out_w !== exp_o[i]) begin
                n_bad++; $display("FAIL rr4_out[%0d] got v=%b %h want v=1 %h", i, valid, out_w, exp_o[i]);
            end
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL rr4_drain got valid=%b want 0", valid); end
    endtask

    task automatic test_backpressure();
        req   = 4'b0100;
        d2    = 16'hBEEF;
        ready = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0100) begin n_bad++; $display("FAIL bp_grant got %b want 0100", gnt); end
        tick();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (valid !== 1'b1 || out_w !== 16'hBEEF || gnt !== 4'b0000) begin
                n_bad++; $display("FAIL bp_hold[%0d] got v=%b %h g=%b want v=1 beef g=0000", i, valid, out_w, gnt);
            end
            tick();
        end
        req   = 4'b0000;
        ready = 1'b1;
        tick();
        n_cmp++;
        if (valid !== 1'b0 || out_w !== 16'hBEEF) begin
            n_bad++; $display("FAIL bp_release got v=%b %h want v=0 beef", valid, out_w);
        end
    endtask

    task automatic test_back_to_back();
        req   = 4'b1000;
        d3    = 16'h5555;
        ready = 1'b0;
        tick();
        n_cmp++;
        if (valid !== 1'b1 || out_w !== 16'h5555) begin
            n_bad++; $display("FAIL b2b_load got v=%b %h want v=1 5555", valid, out_w);
        end
        req   = 4'b0001;
        d0    = 16'h1234;
        ready = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL b2b_gnt got %b want 0001", gnt); end
        tick();
        n_cmp++;
        if (valid !== 1'b1 || out_w !== 16'h1234) begin
            n_bad++; $display("FAIL b2b_swap got v=%b %h want v=1 1234", valid, out_w);
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got valid=%b want 0", valid); end
    endtask

    task automatic test_reset_mid();
        req   = 4'b0010;
        d1    = 16'hAAAA;
        ready = 1'b0;
        tick();
        req = 4'b0000;
        n_cmp++;
        if (valid !== 1'b1 || out_w !== 16'hAAAA) begin
            n_bad++; $display("FAIL rmid_load got v=%b %h want v=1 aaaa", valid, out_w);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (valid !== 1'b0 || out_w !== 16'h0000) begin
            n_bad++; $display("FAIL rmid_async got v=%b %h want v=0 0000", valid, out_w);
        end
        tick();
        reset = 1'b0;
        req   = 4'b1001;
        d0    = 16'h0F0F;
        d3    = 16'hF0F0;
        ready = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rmid_first got %b want 0001", gnt); end
        tick();
        n_cmp++;
        if (gnt !== 4'b1000 || out_w !== 16'h0F0F) begin
            n_bad++; $display("FAIL rmid_second got g=%b %h want g=1000 0f0f", gnt, out_w);
        end
        tick();
        n_cmp++;
        if (out_w !== 16'hF0F0) begin n_bad++; $display("FAIL rmid_out3 got %h want f0f0", out_w); end
    endtask

    // Entered with last=3 and ready high
    task automatic test_pair();
        logic [3:0] exp_g [4];
        exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        req = 4'b0011;
        d0  = 16'h00A0;
        d1  = 16'h00B1;
`ifdef ARB_LOCK_EN
        lock = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (gnt !== 4'b0001) begin n_bad++; $display("FAIL lock_gnt[%0d] got %b want 0001", i, gnt); end
            tick();
        end
        lock = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (gnt !== exp_g[i]) begin n_bad++; $display("FAIL pair_gnt[%0d] got %b want %b", i, gnt, exp_g[i]); end
            tick();
        end
        n_cmp++;
        if (out_w !== 16'h00B1) begin n_bad++; $display("FAIL pair_out got %h want 00b1", out_w); end
        req = 4'b0000;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        req   = 4'b0000;
        ready = 1'b0;
        lock  = 4'b0000;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        test_reset();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_pair();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
